alu_sig_capture: RTL
====================

# alu_sig_capture

Response-side companion to the ALU operand stimulus path. Accepts a stream of ALU result words (for example, `f` from `xor32` or any sibling 32-bit unit) over a valid/ready handshake and compacts them into a running signature with a multiple-input signature register (MISR). After a programmed number of samples, it compares the signature against an expected value and reports pass or fail. It lets directed and self-running ALU tests check thousands of results against a single 32-bit golden value.

## Interface
Parameters:
- `WIDTH`, 32: result/signature width.
- `CNT_W`, 16: sample counter width.
- `POLY`, 32'h04C11DB7: MISR feedback polynomial (bit i set = tap into bit i).
- `SEED`, 32'hFFFFFFFF: signature value loaded on start.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a capture run. Honoured only in IDLE or DONE.
- `num_samples`  in  CNT_W  number of words to compact; latched on accepted start.
- `expected`  in  WIDTH  golden signature; latched on accepted start.
- `f_valid`  in  1  result word present on `f`.
- `f`  in  WIDTH  result word.
- `f_ready`  out  1  block will consume `f` this cycle.
- `busy`  out  1  state is RUN or CHECK.
- `done`  out  1  run complete; held until next accepted start or reset.
- `pass`  out  1  signature matched `expected`; valid while `done`=1, 0 otherwise.
- `signature`  out  WIDTH  current MISR contents.
- `sample_count`  out  CNT_W  words accepted in the current run.

## Operation
- States: IDLE, RUN, CHECK, DONE (registered).
- IDLE/DONE, `start`=1:
  - Latch `num_samples` and `expected`.
  - `signature`<=SEED, `sample_count`<=0, `done`<=0, `pass`<=0.
  - Next state is CHECK if `num_samples`==0, else RUN.
- `start` in RUN or CHECK is ignored. Latched values are not disturbed.
- RUN:
  - `f_ready`=1.
  - On an accept (`f_valid`&&`f_ready`): `signature` <= {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ f, and `sample_count`++.
  - When the accept makes `sample_count` equal the latched target, next state is CHECK.
  - `f_valid`=0 stalls indefinitely with no state change.
- CHECK: one cycle. `pass`<=(signature==expected_latched), `done`<=1, next state DONE. `f_ready`=0.
- DONE: `signature`, `sample_count`, `pass` and `done` hold. `f_ready`=0; `f_valid` is ignored.
- Counter: compares with equality only, never wraps within a run. `num_samples`=2^CNT_W-1 is the maximum.
- Arithmetic: XOR/shift only, no carries. The MISR is exactly WIDTH bits.

## Timing
- Reset (`rst_n`=0 at an edge) from any state:
  - state=IDLE.
  - `f_ready`=0, `busy`=0, `done`=0, `pass`=0, `signature`=0, `sample_count`=0.
- Reset mid-run aborts with no partial result. Reset has priority over `start`.
- `f_ready` and `busy` decode from the registered state only. There is no combinational path from `f_valid` or `start`.
- Start accepted at edge 0: RUN from cycle 1, so the first accept can occur at edge 1.
- Last accept at edge k: CHECK during cycle k+1, and `done`/`pass` are visible after edge k+1.
- Minimum run with N samples and no stalls: N+2 cycles from the start edge to `done`.
- `num_samples`=0: CHECK in cycle 1, `done` after edge 1, and `signature`=SEED.
- `start` together with an `f_valid` in DONE: start wins and that word is not consumed (`f_ready`=0).

## Test plan
- Reset values: hold `rst_n`=0 for 2 cycles with random inputs -> all outputs 0 and `f_ready`=0. Asserting `rst_n`=0 mid-RUN returns to IDLE with `signature`=0.
- Single sample: start with num=1, `expected`=32'h7B3EE248, then `f`=32'h80000001 valid -> `signature`=32'h7B3EE248; `done`=1, `pass`=1 two cycles after the accept edge.
- Two zero samples with stalls: num=2, `expected`=32'hF2BCD925. Present `f`=0 with `f_valid` toggling 1,0,0,1 -> only 2 accepts; intermediate `signature`=32'hFB3EE249, final 32'hF2BCD925, `pass`=1.
- Mismatch: same as the single-sample case but `expected`=32'h7B3EE249 -> `done`=1, `pass`=0, `signature`=32'h7B3EE248.
- Zero count: start with num=0, `expected`=32'hFFFFFFFF -> `done` after 2 edges, `pass`=1, `sample_count`=0, `f_ready` never 1.
- Ignored and restart starts: pulse `start` during RUN with a different num -> no effect. A `start` in DONE clears `done`/`pass` next cycle, reloads SEED, and runs a new capture correctly.

Source files
------------

// File: rtl/alu_sig_capture.sv
// alu_sig_capture: compacts a stream of ALU result words into a MISR signature
// and compares it against a golden value after a programmed number of samples.
// Ports: clk/rst_n (sync active-low); start/num_samples/expected program a run;
//        f_valid/f/f_ready carry result words; busy/done/pass/signature/
//        sample_count report progress and the verdict.
// Latency: an accepted word is folded into the signature at the accepting edge;
//          the verdict is visible one edge after the last accept.
// Backpressure: f_ready is a pure decode of the registered state (high only in
//               RUN), so nothing combinational runs from f_valid or start.
module alu_sig_capture #(
    parameter int               WIDTH = 32,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] POLY  = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] SEED  = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [WIDTH-1:0] expected,
    input  logic             f_valid,
    input  logic [WIDTH-1:0] f,
    output logic             f_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] sample_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] target;
    logic [WIDTH-1:0] exp_q;

    logic             start_ok;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] sig_nxt;

    // Start is only honoured between runs; in RUN/CHECK it is dropped silently.
    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    assign accept   = (state == S_RUN) && f_valid;
    assign cnt_inc  = sample_count + CNT_W'(1);

    // Galois-style MISR step: shift left, fold the MSB back through POLY,
    // then mix in the incoming word. Pure XOR, no carries.
    assign sig_nxt  = {signature[WIDTH-2:0], 1'b0}
                    ^ (signature[WIDTH-1] ? POLY : '0)
                    ^ f;

    assign f_ready  = (state == S_RUN);
    assign busy     = (state == S_RUN) || (state == S_CHECK);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // A zero-length run goes straight to the compare.
                    state_nxt = (num_samples == '0) ? S_CHECK : S_RUN;
                end
            end
            S_RUN: begin
                // Equality only: the counter never needs to wrap within a run.
                if (accept && (cnt_inc == target)) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            target       <= '0;
            exp_q        <= '0;
            signature    <= '0;
            sample_count <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                target       <= num_samples;
                exp_q        <= expected;
                signature    <= SEED;
                sample_count <= '0;
                done         <= 1'b0;
                pass         <= 1'b0;
            end else if (accept) begin
                signature    <= sig_nxt;
                sample_count <= cnt_inc;
            end else if (state == S_CHECK) begin
                pass <= (signature == exp_q);
                done <= 1'b1;
            end
        end
    end

endmodule
